// File: rtl/cordic_z_reader_pkg.sv
// cordic_z_pkg: shared definitions for the hyperbolic-CORDIC Z-constant reader.
//   - czr_state_e : sequencer FSM states
//   - REP_A0/REP_A1 : ROM addresses where the hyperbolic iteration repeats
//   - shift_of()  : ROM address -> shift amount, also used by the X/Y shift datapath
package cordic_z_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_PRESENT,
        S_FIN
    } czr_state_e;

    localparam int unsigned REP_A0 = 3;
    localparam int unsigned REP_A1 = 13;

    // Each repeated iteration shifts the mapping down by one more step.
    function automatic logic [31:0] shift_of(input logic [31:0] a);
        if (a <= REP_A0)
            return a;
        else if (a <= REP_A1)
            return a - 32'd1;
        else
            return a - 32'd2;
    endfunction

endpackage

// File: rtl/cordic_z_reader_if.sv
// cordic_z_reader_if: ROM read port plus Z-constant stream.
//   master (reader): drives EN_ROM1, ADRS, Z_VAL, SHIFT, Z_VALID; receives O_D, Z_READY
//   slave  (ROM + iteration datapath): the mirror image
interface cordic_z_reader_if #(
    parameter int ROM_WIDTH = 32,
    parameter int ADRS_W    = 5
) ();
    logic                 EN_ROM1;
    logic [ADRS_W-1:0]    ADRS;
    logic [ROM_WIDTH-1:0] O_D;
    logic [ROM_WIDTH-1:0] Z_VAL;
    logic [ADRS_W-1:0]    SHIFT;
    logic                 Z_VALID;
    logic                 Z_READY;

    modport master (
        output EN_ROM1, ADRS, Z_VAL, SHIFT, Z_VALID,
        input  O_D, Z_READY
    );

    modport slave (
        input  EN_ROM1, ADRS, Z_VAL, SHIFT, Z_VALID,
        output O_D, Z_READY
    );
endinterface

// File: rtl/cordic_z_reader_skid.sv
// cordic_z_skid: one-entry valid/ready skid buffer (output register + skid entry).
// Only compiled when CZR_PREFETCH_EN is defined.
//   CLK, RST (async active-low), flush (sync clear of both entries)
//   in_valid/in_ready/in_data  : upstream side, in_ready = skid entry empty
//   out_valid/out_ready/out_data : downstream side, registered
`ifdef CZR_PREFETCH_EN
module cordic_z_skid #(
    parameter int W = 37
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         ov_q, sv_q;
    logic [W-1:0] od_q, sd_q;

    assign in_ready  = !sv_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ov_q <= 1'b0;
            sv_q <= 1'b0;
            od_q <= '0;
            sd_q <= '0;
        end else if (flush) begin
            ov_q <= 1'b0;
            sv_q <= 1'b0;
        end else if (ov_q && out_ready) begin
            if (sv_q) begin
                od_q <= sd_q;
                sv_q <= 1'b0;
            end else if (in_valid) begin
                od_q <= in_data;
            end else begin
                ov_q <= 1'b0;
            end
        end else if (in_valid && !sv_q) begin
            if (!ov_q) begin
                od_q <= in_data;
                ov_q <= 1'b1;
            end else begin
                sd_q <= in_data;
                sv_q <= 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/cordic_z_reader.sv
// cordic_z_reader: reads the hyperbolic-CORDIC Z-constant ROM (registered read)
// and streams one (Z_VAL, SHIFT) beat per iteration for ROM addresses 0..ITERS.
//   CLK, RST (async active-low)
//   START (sampled in IDLE), ABORT (sync cancel), ITERS (last address, latched at START)
//   BUSY, DONE (one-cycle pulse after the last handshake)
//   zb : ROM port (EN_ROM1, ADRS, O_D) and Z stream (Z_VAL, SHIFT, Z_VALID, Z_READY)
// Build option CZR_PREFETCH_EN: speculative fetch through a one-entry skid buffer,
// giving one beat per cycle; otherwise three cycles per beat.
module cordic_z_reader
    import cordic_z_pkg::*;
#(
    parameter int ROM_WIDTH = 32,
    parameter int ADRS_W    = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADRS_W-1:0] ITERS,
    output logic              BUSY,
    output logic              DONE,
    cordic_z_reader_if.master zb
);
    czr_state_e        state_q, state_d;
    logic [ADRS_W-1:0] last_q, idx_q, adrs_q;
    logic              en_q, busy_q, done_q;
    logic              abort_act, hs, is_last;

    assign abort_act = ABORT && (state_q != S_IDLE);
    assign is_last   = (idx_q == last_q);

    assign zb.EN_ROM1 = en_q;
    assign zb.ADRS    = adrs_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (START) state_d = S_FETCH;
            S_FETCH:   state_d = S_CAPT;
            S_CAPT:    state_d = S_PRESENT;
`ifdef CZR_PREFETCH_EN
            S_PRESENT: if (hs && is_last) state_d = S_FIN;
`else
            S_PRESENT: if (hs) state_d = is_last ? S_FIN : S_FETCH;
`endif
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_act)
            state_d = S_IDLE;
    end

`ifdef CZR_PREFETCH_EN
    // Fetch runs ahead of the output. Words in flight are counted across the
    // request cycle, the ROM output register, the output register and the skid
    // entry; at most three may be outstanding. The ROM output holds its word while
    // no new read is issued, so it acts as the third storage slot.
    logic                        rd_q, fdone_q, can_issue, sk_in_ready, sk_out_valid;
    logic [ADRS_W-1:0]           rd_adr_q;
    logic [2:0]                  outstanding;
    logic [ADRS_W+ROM_WIDTH-1:0] sk_in_data, sk_out_data;

    assign hs          = sk_out_valid && zb.Z_READY;
    assign outstanding = 3'(en_q) + 3'(rd_q) + 3'(sk_out_valid) + 3'(!sk_in_ready);
    assign can_issue   = (state_q inside {S_FETCH, S_CAPT, S_PRESENT}) && !fdone_q
                         && ((outstanding - 3'(hs)) <= 3'd2);
    assign sk_in_data  = {ADRS_W'(shift_of(32'(rd_adr_q))), zb.O_D};

    assign zb.Z_VALID = sk_out_valid;
    assign zb.Z_VAL   = sk_out_data[ROM_WIDTH-1:0];
    assign zb.SHIFT   = sk_out_data[ROM_WIDTH +: ADRS_W];

    cordic_z_skid #(.W(ADRS_W + ROM_WIDTH)) u_skid (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (abort_act),
        .in_valid  (rd_q),
        .in_ready  (sk_in_ready),
        .in_data   (sk_in_data),
        .out_valid (sk_out_valid),
        .out_ready (zb.Z_READY),
        .out_data  (sk_out_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q   <= '0;
            idx_q    <= '0;
            adrs_q   <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            rd_adr_q <= '0;
            fdone_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                en_q   <= 1'b0;
                rd_q   <= 1'b0;
                busy_q <= 1'b0;
            end else if (state_q == S_IDLE) begin
                if (START) begin
                    last_q  <= ITERS;
                    idx_q   <= '0;
                    adrs_q  <= '0;
                    en_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    fdone_q <= (ITERS == '0);
                end
            end else if (state_q == S_FIN) begin
                busy_q <= 1'b0;
            end else begin
                en_q <= can_issue;
                if (can_issue) begin
                    adrs_q  <= adrs_q + ADRS_W'(1);
                    fdone_q <= ((adrs_q + ADRS_W'(1)) == last_q);
                end
                // A read completing while a word still sits in the ROM output
                // implies the skid entry is free, so that word always lands here.
                if (en_q) begin
                    rd_q     <= 1'b1;
                    rd_adr_q <= adrs_q;
                end else if (rd_q && sk_in_ready) begin
                    rd_q <= 1'b0;
                end
                if (hs) begin
                    if (is_last)
                        done_q <= 1'b1;
                    else
                        idx_q <= idx_q + ADRS_W'(1);
                end
            end
        end
    end
`else
    logic [ROM_WIDTH-1:0] zval_q;
    logic [ADRS_W-1:0]    shift_q;
    logic                 zv_q;

    assign hs         = zv_q && zb.Z_READY;
    assign zb.Z_VALID = zv_q;
    assign zb.Z_VAL   = zval_q;
    assign zb.SHIFT   = shift_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q  <= '0;
            idx_q   <= '0;
            adrs_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zval_q  <= '0;
            shift_q <= '0;
            zv_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                en_q   <= 1'b0;
                zv_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (START) begin
                            last_q <= ITERS;
                            idx_q  <= '0;
                            adrs_q <= '0;
                            en_q   <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    S_FETCH: en_q <= 1'b0;
                    S_CAPT: begin
                        zval_q  <= zb.O_D;
                        shift_q <= ADRS_W'(shift_of(32'(idx_q)));
                        zv_q    <= 1'b1;
                    end
                    S_PRESENT: begin
                        if (hs) begin
                            zv_q <= 1'b0;
                            if (is_last) begin
                                done_q <= 1'b1;
                            end else begin
                                idx_q  <= idx_q + ADRS_W'(1);
                                adrs_q <= idx_q + ADRS_W'(1);
                                en_q   <= 1'b1;
                            end
                        end
                    end
                    S_FIN: busy_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_cordic_z_reader.sv
// Testbench for cordic_z_reader: directed sequences against a registered-read ROM
// model with known constants at addresses 0, 3/4, 13/14 and 31.
// Honours CZR_PREFETCH_EN (one beat per cycle instead of three).
module tb_cordic_z_reader;
`ifdef CZR_PREFETCH_EN
    localparam int SPACING = 1;
`else
    localparam int SPACING = 3;
`endif

    logic       CLK;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic [4:0] ITERS;
    logic       BUSY;
    logic       DONE;

    cordic_z_reader_if #(.ROM_WIDTH(32), .ADRS_W(5)) zb ();

    cordic_z_reader #(.ROM_WIDTH(32), .ADRS_W(5)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .ABORT (ABORT),
        .ITERS (ITERS),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .zb    (zb)
    );

    logic [31:0] rom [32];
    int shift_tab [32] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 12, 13,
                           14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29};

    int n_checks = 0;
    int n_errs   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (zb.EN_ROM1)
            zb.O_D <= rom[zb.ADRS];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left on a negedge with the DUT idle.
    task automatic run_seq(input logic [4:0] iters, input bit rnd, input int abort_beat,
                           input bit start_busy, input bit start_at_done);
        int beats, c, done_c, last_hs, n_exp;
        bit stall, fin, abrt;
        logic [31:0] pv;
        logic [4:0]  ps;
        beats = 0; done_c = -1; last_hs = -1; n_exp = int'(iters) + 1;
        stall = 1'b0; fin = 1'b0; abrt = 1'b0; pv = '0; ps = '0;
        ITERS = iters; START = 1'b1; ABORT = 1'b0; zb.Z_READY = 1'b1;
        c = 0;
        while (!fin && c < 400) begin
            @(negedge CLK);
            c++;
            START = 1'b0;
            ABORT = 1'b0;
            if (abrt) begin
                check_eq("abort_zvalid", 32'(zb.Z_VALID), 0);
                check_eq("abort_en", 32'(zb.EN_ROM1), 0);
                check_eq("abort_busy", 32'(BUSY), 0);
                check_eq("abort_done", 32'(DONE), 0);
                fin = 1'b1;
            end else if (done_c >= 0) begin
                check_eq("done_width", 32'(DONE), 0);
                check_eq("busy_after_done", 32'(BUSY), 0);
                check_eq("en_after_done", 32'(zb.EN_ROM1), 0);
                fin = 1'b1;
            end else begin
                if (start_busy && c == 1) begin
                    check_eq("busy_after_start", 32'(BUSY), 1);
                    ITERS = 5'd31;
                    START = 1'b1;
                end
                zb.Z_READY = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (stall) begin
                    check_eq("stall_valid", 32'(zb.Z_VALID), 1);
                    check_eq("stall_zval", zb.Z_VAL, pv);
                    check_eq("stall_shift", 32'(zb.SHIFT), 32'(ps));
                end
                if (zb.Z_VALID && beats == 0 && !stall)
                    check_eq("first_valid_lat", c, 3);
`ifndef CZR_PREFETCH_EN
                if (zb.Z_VALID)
                    check_eq("no_fetch_while_valid", 32'(zb.EN_ROM1), 0);
                if (zb.EN_ROM1)
                    check_eq("fetch_adrs", 32'(zb.ADRS), beats);
`endif
                if (DONE) begin
                    done_c = c;
                    check_eq("done_after_last", c, last_hs + 1);
                    check_eq("beat_count", beats, n_exp);
                    if (start_at_done) begin
                        ITERS = 5'd7;
                        START = 1'b1;
                    end
                end
                if (zb.Z_VALID && beats == abort_beat) begin
                    ABORT = 1'b1;
                    abrt  = 1'b1;
                end else if (zb.Z_VALID && zb.Z_READY) begin
                    if (beats >= n_exp) begin
                        check_eq("extra_beat", beats, n_exp - 1);
                    end else begin
                        check_eq("zval", zb.Z_VAL, rom[beats]);
                        check_eq("shift", 32'(zb.SHIFT), shift_tab[beats]);
                        if (!rnd)
                            check_eq("beat_cycle", c, 3 + beats * SPACING);
                    end
                    last_hs = c;
                    beats++;
                end
                stall = zb.Z_VALID && !zb.Z_READY;
                pv = zb.Z_VAL;
                ps = zb.SHIFT;
            end
        end
        check_eq("seq_completed", 32'(fin), 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rom[i] = 32'hC0000000 | 32'(i * 32'h00010101);
        rom[0]  = 32'hBF8C9F54;
        rom[3]  = 32'hBE002AC4;
        rom[4]  = 32'hBE002AC4;
        rom[13] = 32'hB9800000;
        rom[14] = 32'hB9800000;
        rom[31] = 32'hB1000000;

        RST = 1'b0; START = 1'b0; ABORT = 1'b0; ITERS = '0; zb.Z_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_en", 32'(zb.EN_ROM1), 0);
        check_eq("rst_adrs", 32'(zb.ADRS), 0);
        check_eq("rst_zval", zb.Z_VAL, 0);
        check_eq("rst_shift", 32'(zb.SHIFT), 0);
        check_eq("rst_zvalid", 32'(zb.Z_VALID), 0);
        check_eq("rst_busy", 32'(BUSY), 0);
        check_eq("rst_done", 32'(DONE), 0);
        RST = 1'b1;
        @(negedge CLK);

        run_seq(5'd0, 1'b0, -1, 1'b0, 1'b1);
        run_seq(5'd4, 1'b0, -1, 1'b0, 1'b0);
        run_seq(5'd15, 1'b1, -1, 1'b0, 1'b0);
        run_seq(5'd3, 1'b0, -1, 1'b1, 1'b0);
        run_seq(5'd5, 1'b0, 2, 1'b0, 1'b0);

        // Reset asserted during FETCH of a new run.
        ITERS = 5'd9;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check_eq("fetch_en_pre_rst", 32'(zb.EN_ROM1), 1);
        #2 RST = 1'b0;
        #1;
        check_eq("midrst_en", 32'(zb.EN_ROM1), 0);
        check_eq("midrst_adrs", 32'(zb.ADRS), 0);
        check_eq("midrst_zval", zb.Z_VAL, 0);
        check_eq("midrst_shift", 32'(zb.SHIFT), 0);
        check_eq("midrst_zvalid", 32'(zb.Z_VALID), 0);
        check_eq("midrst_busy", 32'(BUSY), 0);
        check_eq("midrst_done", 32'(DONE), 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        run_seq(5'd2, 1'b0, -1, 1'b0, 1'b0);
        run_seq(5'd31, 1'b0, -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
